clb_cfg_loader: RTL and testbench

//  Configuration stage directly upstream of the CLB array. Accepts a serial

---
 rtl/clb_cfg_loader.sv | 77 +++++++
 tb/tb_clb_cfg_loader.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/clb_cfg_loader.sv
// clb_cfg_loader: assembles MSB-first serial config frames and writes one frame per CLB
// Ports: clk_i/rst_i clock and synchronous active-high reset; start_i begins a load;
//   ser_data_i/ser_valid_i/ser_ready_o serial bit handshake; bits_o frame to the CLBs;
//   wr_en_o one-hot CLB write strobe; busy_o load in progress; done_o load complete.
module clb_cfg_loader #(
    parameter int NUM_CLB = 4,
    parameter int CFG_W   = 23
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic               ser_data_i,
    input  logic               ser_valid_i,
    output logic               ser_ready_o,
    output logic [CFG_W-1:0]   bits_o,
    output logic [NUM_CLB-1:0] wr_en_o,
    output logic               busy_o,
    output logic               done_o
);
    localparam int IDX_W = NUM_CLB > 1 ? $clog2(NUM_CLB) : 1;
    localparam int CNT_W = CFG_W > 1 ? $clog2(CFG_W) : 1;

    typedef enum logic [2:0] {IDLE, SHIFT, WRITE, HOLD, DONE} state_t;

    state_t             state, state_n;
    logic [CNT_W-1:0]   cnt;
    logic [IDX_W-1:0]   idx;
    logic [CFG_W-1:0]   sreg;
    logic [CFG_W-1:0]   frame;
    logic               take, last_bit, last_clb;

    assign take     = ser_valid_i & ser_ready_o;
    assign last_bit = cnt == CNT_W'(CFG_W - 1);
    assign last_clb = idx == IDX_W'(NUM_CLB - 1);
    assign frame    = {sreg[CFG_W-2:0], ser_data_i};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= IDLE;
            cnt     <= '0;
            idx     <= '0;
            sreg    <= '0;
            bits_o  <= '0;
            wr_en_o <= '0;
        end else begin
            state   <= state_n;
            wr_en_o <= '0;
            if ((state == IDLE || state == DONE) && start_i) begin
                cnt <= '0;
                idx <= '0;
            end
            if (state == SHIFT && take) begin
                sreg <= frame;
                cnt  <= last_bit ? '0 : cnt + 1'b1;
            end
            // Outputs are loaded on the edge entering WRITE so the strobe is visible for the whole WRITE cycle.
            if (state == SHIFT && take && last_bit) begin
                bits_o  <= frame;
                wr_en_o <= NUM_CLB'(1) << idx;
            end
            if (state == HOLD && !last_clb) idx <= idx + 1'b1;
        end
    end

    always_comb begin
        state_n = (state == IDLE || state == DONE) ? (start_i ? SHIFT : state) :
                  (state == SHIFT) ? ((take && last_bit) ? WRITE : SHIFT) :
                  (state == WRITE) ? HOLD :
                  (state == HOLD)  ? (last_clb ? DONE : SHIFT) : IDLE;
    end

    always_comb begin
        ser_ready_o = state == SHIFT;
        busy_o      = state == SHIFT || state == WRITE || state == HOLD;
        done_o      = state == DONE;
    end
endmodule

// File: tb/tb_clb_cfg_loader.sv
// tb_clb_cfg_loader: randomized self-checking bench for clb_cfg_loader
module tb_clb_cfg_loader;
    localparam int NUM_CLB = 4;
    localparam int CFG_W   = 23;

    logic               clk = 1'b0;
    logic               rst_i = 1'b1;
    logic               start_i = 1'b0;
    logic               ser_data_i = 1'b0;
    logic               ser_valid_i = 1'b0;
    logic               ser_ready_o;
    logic [CFG_W-1:0]   bits_o;
    logic [NUM_CLB-1:0] wr_en_o;
    logic               busy_o;
    logic               done_o;

    int n_chk = 0;
    int n_fail = 0;
    bit chk_on = 0;

    always #5 clk = ~clk;

    clb_cfg_loader #(.NUM_CLB(NUM_CLB), .CFG_W(CFG_W)) dut (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .ser_data_i(ser_data_i),
        .ser_valid_i(ser_valid_i), .ser_ready_o(ser_ready_o), .bits_o(bits_o),
        .wr_en_o(wr_en_o), .busy_o(busy_o), .done_o(done_o)
    );

    logic [CFG_W-1:0] clb_cfg [NUM_CLB];
    always @(posedge clk)
        for (int i = 0; i < NUM_CLB; i++) if (wr_en_o[i]) clb_cfg[i] <= bits_o;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: counts accepted bits per frame, then spends one strobe cycle and one hold cycle.
    bit                 m_busy, m_done;
    int                 m_nbits, m_clb, m_after;
    logic [CFG_W-1:0]   m_acc, m_bits;
    logic [NUM_CLB-1:0] m_wr;
    logic [CFG_W-1:0]   sb_q[$];
    int                 sb_n;

    initial forever begin
        @(posedge clk);
        m_wr = '0;
        if (rst_i) begin
            m_busy = 0; m_done = 0; m_nbits = 0; m_clb = 0; m_after = 0; m_bits = '0;
            sb_q.delete(); sb_n = 0;
        end else if (!m_busy) begin
            if (start_i) begin
                m_busy = 1; m_done = 0; m_nbits = 0; m_clb = 0; m_after = 0; sb_n = 0;
            end
        end else if (m_after == 0) begin
            if (ser_valid_i) begin
                m_acc = {m_acc[CFG_W-2:0], ser_data_i};
                m_nbits++;
                if (m_nbits == CFG_W) begin
                    m_bits = m_acc; m_wr = NUM_CLB'(1) << m_clb; m_after = 1; m_nbits = 0;
                end
            end
        end else if (m_after == 1) m_after = 2;
        else begin
            m_after = 0;
            if (m_clb == NUM_CLB - 1) begin m_busy = 0; m_done = 1; end
            else m_clb++;
        end
    end

    initial forever begin
        @(negedge clk);
        if (chk_on) begin
            check("wr_en", wr_en_o, m_wr);
            check("bits", bits_o, m_bits);
            check("busy", busy_o, m_busy);
            check("done", done_o, m_done);
            check("ready", ser_ready_o, m_busy && m_after == 0);
            if (wr_en_o != '0) begin
                check("strobe_order", wr_en_o, NUM_CLB'(1) << sb_n);
                if (sb_q.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL sb_frame: strobe %b with no frame outstanding", wr_en_o);
                end else check("sb_frame", bits_o, sb_q.pop_front());
                sb_n++;
            end
        end
    end

    logic [CFG_W-1:0] frm [NUM_CLB];

    // pct<0 selects valid on one cycle in three; glitch_at/rst_at are bit indices (-1 = never).
    task automatic load(input int pct, input int glitch_at, input int rst_at, output int t);
        int k = 0;
        int g = 0;
        bit v;
        t = 0;
        @(negedge clk);
        for (int i = 0; i < NUM_CLB; i++) sb_q.push_back(frm[i]);
        start_i = 1'b1;
        ser_valid_i = 1'($urandom);
        ser_data_i = 1'($urandom);
        while (k < NUM_CLB * CFG_W && g < 20000) begin
            @(negedge clk); g++; t++;
            start_i = (k == glitch_at);
            if (k == rst_at) begin
                rst_i = 1'b1; start_i = 1'b0; ser_valid_i = 1'b0;
                @(negedge clk);
                rst_i = 1'b0;
                check("rst_wr_en", wr_en_o, 0);
                check("rst_bits", bits_o, 0);
                check("rst_busy", busy_o, 0);
                check("rst_ready", ser_ready_o, 0);
                check("rst_done", done_o, 0);
                return;
            end
            v = pct < 0 ? (g % 3 == 0) : ($urandom_range(0, 99) < pct);
            ser_valid_i = v;
            ser_data_i = frm[k / CFG_W][CFG_W - 1 - k % CFG_W];
            if (v && ser_ready_o) k++;
        end
        check("bits_sent", k, NUM_CLB * CFG_W);
        g = 0;
        while (!done_o && g < 100) begin
            @(negedge clk); g++; t++;
            start_i = 1'b0;
            ser_valid_i = 1'($urandom);
            ser_data_i = 1'($urandom);
        end
        check("done_reached", done_o, 1);
        check("sb_drained", sb_q.size(), 0);
    endtask

    task automatic check_clbs();
        for (int i = 0; i < NUM_CLB; i++) check($sformatf("clb%0d_cfg", i), clb_cfg[i], frm[i]);
    endtask

    initial begin
        int t;
        logic [CFG_W-1:0] old1;
        repeat (2) @(negedge clk);
        check("reset_bits", bits_o, 0);
        check("reset_wr_en", wr_en_o, 0);
        check("reset_busy", busy_o, 0);
        check("reset_done", done_o, 0);
        check("reset_ready", ser_ready_o, 0);
        rst_i = 1'b0;
        chk_on = 1;

        frm = '{23'h0035237, 23'h7FFFFF, 23'h000001, 23'h5A5A5A};
        load(100, -1, -1, t);
        check("load_cycles", t, 101);
        check("clb0_route", clb_cfg[0][22:16], 7'h03);
        check("clb0_lut", clb_cfg[0][15:0], 16'h5237);
        check("clb1_cfg", clb_cfg[1], 23'h7FFFFF);
        check("clb2_cfg", clb_cfg[2], 23'h000001);
        check("clb3_cfg", clb_cfg[3], 23'h5A5A5A);

        load(-1, -1, -1, t);
        check_clbs();

        load(100, 10, -1, t);
        check("glitch_load_cycles", t, 101);
        check_clbs();

        old1 = frm[1];
        frm = '{23'h123456, 23'h0F0F0F, 23'h3C3C3C, 23'h700001};
        load(100, -1, CFG_W + 10, t);
        check("rst_clb0_kept", clb_cfg[0], frm[0]);
        check("rst_clb1_kept", clb_cfg[1], old1);
        repeat (3) @(negedge clk);
        load(100, -1, -1, t);
        check("post_rst_cycles", t, 101);
        check_clbs();

        repeat (6) begin
            for (int i = 0; i < NUM_CLB; i++) frm[i] = CFG_W'($urandom);
            load(int'($urandom_range(20, 100)), -1, -1, t);
            check_clbs();
            repeat ($urandom_range(0, 5)) begin
                @(negedge clk);
                ser_valid_i = 1'($urandom);
                ser_data_i = 1'($urandom);
            end
        end

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish, %0d failures so far", n_fail);
        $fatal(1, "timeout");
    end
endmodule
